// File: rtl/wb_sram_port_arbiter.sv
// wb_sram_port_arbiter: round-robin two-port Wishbone arbiter for the sky130 OpenRAM RW port; optional bus lock via WB_SRAM_ARB_LOCK_EN.
module wb_sram_port_arbiter #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int WB_ADDR_WIDTH  = 10
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_a_stb_i,
    input  logic                      wbs_a_cyc_i,
    input  logic                      wbs_a_we_i,
    input  logic [3:0]                wbs_a_sel_i,
    input  logic [31:0]               wbs_a_dat_i,
    input  logic [WB_ADDR_WIDTH-1:0]  wbs_a_adr_i,
    output logic                      wbs_a_ack_o,
    output logic [31:0]               wbs_a_dat_o,
    input  logic                      wbs_b_stb_i,
    input  logic                      wbs_b_cyc_i,
    input  logic                      wbs_b_we_i,
    input  logic [3:0]                wbs_b_sel_i,
    input  logic [31:0]               wbs_b_dat_i,
    input  logic [WB_ADDR_WIDTH-1:0]  wbs_b_adr_i,
    output logic                      wbs_b_ack_o,
    output logic [31:0]               wbs_b_dat_o,
    output logic                      ram_clk0,
    output logic                      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr0,
    output logic [31:0]               ram_din0,
    input  logic [31:0]               ram_dout0,
    output logic [1:0]                grant_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                grant_q, grant_d;
    logic                      last_b_q, last_b_d;
    logic                      we_q, we_d;
    logic                      csb_q, csb_d;
    logic                      web_q, web_d;
    logic [3:0]                wmask_q, wmask_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               din_q, din_d;
    logic                      ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic [31:0]               dat_a_q, dat_a_d, dat_b_q, dat_b_d;
    logic                      req_a, req_b, win_b, lock_hit, own_req, own_cyc;
    logic                      unused_adr;
`ifdef WB_SRAM_ARB_LOCK_EN
    logic                      lock_q, lock_d, lock_b_q, lock_b_d;
`endif

    assign unused_adr = ^{wbs_a_adr_i[1:0], wbs_b_adr_i[1:0]};

    always_comb begin
        req_a   = wbs_a_cyc_i & wbs_a_stb_i;
        req_b   = wbs_b_cyc_i & wbs_b_stb_i;
        own_req = grant_q[1] ? req_b : req_a;
        own_cyc = grant_q[1] ? wbs_b_cyc_i : wbs_a_cyc_i;
`ifdef WB_SRAM_ARB_LOCK_EN
        lock_hit = lock_q & (lock_b_q ? req_b : req_a);
        win_b    = lock_hit ? lock_b_q : req_b & (~req_a | ~last_b_q);
        lock_d   = lock_q;
        lock_b_d = lock_b_q;
`else
        lock_hit = 1'b0;
        win_b    = req_b & (~req_a | ~last_b_q);
`endif
        state_d  = state_q;
        grant_d  = grant_q;
        last_b_d = last_b_q;
        we_d     = we_q;
        csb_d    = csb_q;
        web_d    = web_q;
        wmask_d  = wmask_q;
        addr_d   = addr_q;
        din_d    = din_q;
        ack_a_d  = ack_a_q;
        ack_b_d  = ack_b_q;
        dat_a_d  = dat_a_q;
        dat_b_d  = dat_b_q;
        case (state_q)
            IDLE: begin
`ifdef WB_SRAM_ARB_LOCK_EN
                if (lock_q && !(lock_b_q ? wbs_b_cyc_i : wbs_a_cyc_i))
                    lock_d = 1'b0;
`endif
                if (req_a || req_b) begin
                    state_d  = ACCESS;
                    grant_d  = win_b ? 2'b10 : 2'b01;
                    last_b_d = lock_hit ? last_b_q : win_b;
                    we_d     = win_b ? wbs_b_we_i : wbs_a_we_i;
                    csb_d    = 1'b0;
                    web_d    = ~(win_b ? wbs_b_we_i : wbs_a_we_i);
                    wmask_d  = win_b ? wbs_b_sel_i : wbs_a_sel_i;
                    addr_d   = win_b ? wbs_b_adr_i[WB_ADDR_WIDTH-1:2] : wbs_a_adr_i[WB_ADDR_WIDTH-1:2];
                    din_d    = win_b ? wbs_b_dat_i : wbs_a_dat_i;
                end
            end
            ACCESS: begin
                state_d = RESP;
                csb_d   = 1'b1;
                web_d   = 1'b1;
                wmask_d = 4'b0;
            end
            RESP: begin
                state_d = DONE;
                if (own_req) begin
                    ack_a_d = grant_q[0];
                    ack_b_d = grant_q[1];
                    dat_a_d = grant_q[0] ? (we_q ? 32'b0 : ram_dout0) : dat_a_q;
                    dat_b_d = grant_q[1] ? (we_q ? 32'b0 : ram_dout0) : dat_b_q;
                end
            end
            default: begin
                state_d = IDLE;
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                grant_d = 2'b00;
`ifdef WB_SRAM_ARB_LOCK_EN
                lock_d   = own_cyc;
                lock_b_d = grant_q[1];
`endif
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            csb_q    <= 1'b1;
            web_q    <= 1'b1;
            wmask_q  <= 4'b0;
            addr_q   <= '0;
            din_q    <= 32'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            dat_a_q  <= 32'b0;
            dat_b_q  <= 32'b0;
`ifdef WB_SRAM_ARB_LOCK_EN
            lock_q   <= 1'b0;
            lock_b_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            csb_q    <= csb_d;
            web_q    <= web_d;
            wmask_q  <= wmask_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            dat_a_q  <= dat_a_d;
            dat_b_q  <= dat_b_d;
`ifdef WB_SRAM_ARB_LOCK_EN
            lock_q   <= lock_d;
            lock_b_q <= lock_b_d;
`endif
        end
    end

    assign ram_clk0    = wb_clk_i;
    assign ram_csb0    = csb_q;
    assign ram_web0    = web_q;
    assign ram_wmask0  = wmask_q;
    assign ram_addr0   = addr_q;
    assign ram_din0    = din_q;
    assign wbs_a_ack_o = ack_a_q;
    assign wbs_b_ack_o = ack_b_q;
    assign wbs_a_dat_o = dat_a_q;
    assign wbs_b_dat_o = dat_b_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_wb_sram_port_arbiter.sv
// tb_wb_sram_port_arbiter: vector table plus scoreboard bench with a behavioural SRAM model; honours WB_SRAM_ARB_LOCK_EN.
module tb_wb_sram_port_arbiter;

    typedef struct {
        bit          p;
        bit          we;
        logic [9:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          p;
        logic [31:0] d;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_stb = 0, a_cyc = 0, a_we = 0, b_stb = 0, b_cyc = 0, b_we = 0;
    logic [3:0]  a_sel = 0, b_sel = 0;
    logic [31:0] a_dat = 0, b_dat = 0;
    logic [9:0]  a_adr = 0, b_adr = 0;
    logic        ack_a, ack_b;
    logic [31:0] dat_a, dat_b;
    logic        ram_clk0, ram_csb0, ram_web0;
    logic [3:0]  ram_wmask0;
    logic [7:0]  ram_addr0;
    logic [31:0] ram_din0;
    logic [31:0] ram_dout0 = 0;
    logic [1:0]  grant;
    logic [31:0] mem [256];
    sb_t         sb [$];
    sb_t         mon_e;
    vec_t        tbl [12];
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    wb_sram_port_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_a_stb_i(a_stb), .wbs_a_cyc_i(a_cyc), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
        .wbs_a_dat_i(a_dat), .wbs_a_adr_i(a_adr), .wbs_a_ack_o(ack_a), .wbs_a_dat_o(dat_a),
        .wbs_b_stb_i(b_stb), .wbs_b_cyc_i(b_cyc), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
        .wbs_b_dat_i(b_dat), .wbs_b_adr_i(b_adr), .wbs_b_ack_o(ack_b), .wbs_b_dat_o(dat_b),
        .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
        .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0), .grant_o(grant)
    );

    // Behavioural macro: masked write, registered read valid the cycle after csb0 is low.
    always @(posedge clk) begin
        if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int i = 0; i < 4; i++)
                    if (ram_wmask0[i]) mem[ram_addr0][8*i +: 8] <= ram_din0[8*i +: 8];
            end else
                ram_dout0 <= mem[ram_addr0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit p, input bit on, input bit we, input logic [9:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
        if (!p) begin
            a_cyc = on; a_stb = on; a_we = we; a_adr = adr; a_sel = sel; a_dat = dat;
        end else begin
            b_cyc = on; b_stb = on; b_we = we; b_adr = adr; b_sel = sel; b_dat = dat;
        end
    endtask

    task automatic txn(input vec_t v);
        logic [31:0] other;
        other = v.p ? dat_a : dat_b;
        set_req(v.p, 1, v.we, v.adr, v.sel, v.dat);
        sb.push_back('{v.p, v.exp});
        @(negedge clk);
        chk("grant", {30'b0, grant}, v.p ? 32'd2 : 32'd1);
        chk("csb_active", {31'b0, ram_csb0}, 32'd0);
        chk("web", {31'b0, ram_web0}, {31'b0, !v.we});
        chk("wmask", {28'b0, ram_wmask0}, {28'b0, v.sel});
        chk("addr", {24'b0, ram_addr0}, {24'b0, v.adr[9:2]});
        chk("din", ram_din0, v.dat);
        @(negedge clk);
        chk("csb_release", {31'b0, ram_csb0}, 32'd0 + 1);
        chk("web_release", {31'b0, ram_web0}, 32'd0 + 1);
        chk("ack_early", {31'b0, v.p ? ack_b : ack_a}, 32'd0);
        @(negedge clk);
        chk("ack", {31'b0, v.p ? ack_b : ack_a}, 32'd1);
        chk("ack_other", {31'b0, v.p ? ack_a : ack_b}, 32'd0);
        set_req(v.p, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ack_width", {30'b0, ack_a, ack_b}, 32'd0);
        chk("grant_idle", {30'b0, grant}, 32'd0);
        chk("dat_other_hold", v.p ? dat_a : dat_b, other);
    endtask

    always @(negedge clk) begin
        if (!rst && (ack_a || ack_b)) begin
            chk("ack_grant", {30'b0, grant}, ack_b ? 32'd2 : 32'd1);
            chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("ack_port", {31'b0, ack_b}, {31'b0, mon_e.p});
                chk("rdata", mon_e.p ? dat_b : dat_a, mon_e.d);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'b0;
        tbl[0]  = '{0, 1, 10'h010, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{0, 0, 10'h010, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{0, 1, 10'h020, 4'hF, 32'h11223344, 32'h0};
        tbl[3]  = '{1, 1, 10'h020, 4'h1, 32'h000000AA, 32'h0};
        tbl[4]  = '{0, 0, 10'h020, 4'hF, 32'h0,        32'h112233AA};
        tbl[5]  = '{1, 0, 10'h021, 4'hF, 32'h0,        32'h112233AA};
        tbl[6]  = '{1, 1, 10'h3FC, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[7]  = '{0, 0, 10'h3FF, 4'hF, 32'h0,        32'hCAFEF00D};
        tbl[8]  = '{1, 1, 10'h3FC, 4'hA, 32'h12345678, 32'h0};
        tbl[9]  = '{1, 0, 10'h3FC, 4'hF, 32'h0,        32'h12FE560D};
        tbl[10] = '{0, 1, 10'h000, 4'h6, 32'hFFFFFFFF, 32'h0};
        tbl[11] = '{1, 0, 10'h002, 4'hF, 32'h0,        32'h00FFFF00};

        @(negedge clk);
        chk("rst_csb", {31'b0, ram_csb0}, 32'd1);
        chk("rst_web", {31'b0, ram_web0}, 32'd1);
        chk("rst_wmask", {28'b0, ram_wmask0}, 32'd0);
        chk("rst_addr", {24'b0, ram_addr0}, 32'd0);
        chk("rst_din", ram_din0, 32'd0);
        chk("rst_ack", {30'b0, ack_a, ack_b}, 32'd0);
        chk("rst_dat_a", dat_a, 32'd0);
        chk("rst_dat_b", dat_b, 32'd0);
        chk("rst_grant", {30'b0, grant}, 32'd0);
        chk("clk_pass_lo", {31'b0, ram_clk0}, {31'b0, clk});
        rst = 1'b0;
        #6 chk("clk_pass_hi", {31'b0, ram_clk0}, {31'b0, clk});
        @(negedge clk);

        for (int i = 0; i < 12; i++) txn(tbl[i]);

        // Reset pulsed while a B read is in ACCESS.
        set_req(1, 1, 0, 10'h020, 4'hF, 0);
        @(negedge clk);
        chk("mid_csb_active", {31'b0, ram_csb0}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_csb", {31'b0, ram_csb0}, 32'd1);
        chk("mid_rst_ack", {31'b0, ack_b}, 32'd0);
        chk("mid_rst_grant", {30'b0, grant}, 32'd0);
        set_req(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_ack_b", {31'b0, ack_b}, 32'd0);
        end

        // Simultaneous reads right after reset: A first, B sampled four cycles later.
        set_req(0, 1, 0, 10'h010, 4'hF, 0);
        set_req(1, 1, 0, 10'h020, 4'hF, 0);
        sb.push_back('{0, 32'hDEADBEEF});
        sb.push_back('{1, 32'h112233AA});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("tie_grant_a", {30'b0, grant}, 32'd1);
            if (k == 3) begin
                chk("tie_ack_a", {31'b0, ack_a}, 32'd1);
                set_req(0, 0, 0, 0, 0, 0);
            end
            if (k == 4) chk("tie_gap", {30'b0, grant}, 32'd0);
            if (k == 5) begin
                chk("tie_grant_b", {30'b0, grant}, 32'd2);
                chk("tie_addr_b", {24'b0, ram_addr0}, 32'h08);
            end
            if (k < 7) chk("tie_b_wait", {31'b0, ack_b}, 32'd0);
            if (k == 7) begin
                chk("tie_ack_b", {31'b0, ack_b}, 32'd1);
                set_req(1, 0, 0, 0, 0, 0);
            end
        end

        // A streams back-to-back while B requests once.
        set_req(0, 1, 0, 10'h010, 4'hF, 0);
        set_req(1, 1, 0, 10'h020, 4'hF, 0);
`ifdef WB_SRAM_ARB_LOCK_EN
        sb.push_back('{0, 32'hDEADBEEF});
        sb.push_back('{0, 32'hDEADBEEF});
        sb.push_back('{0, 32'hDEADBEEF});
        sb.push_back('{1, 32'h112233AA});
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1 || k == 5 || k == 9) chk("lock_grant_a", {30'b0, grant}, 32'd1);
            if (k == 11) set_req(0, 0, 0, 0, 0, 0);
            if (k == 13) chk("lock_grant_b", {30'b0, grant}, 32'd2);
            if (k < 15) chk("lock_b_wait", {31'b0, ack_b}, 32'd0);
            if (k == 15) begin
                chk("lock_ack_b", {31'b0, ack_b}, 32'd1);
                set_req(1, 0, 0, 0, 0, 0);
            end
        end
`else
        sb.push_back('{0, 32'hDEADBEEF});
        sb.push_back('{1, 32'h112233AA});
        sb.push_back('{0, 32'hDEADBEEF});
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1 || k == 9) chk("rr_grant_a", {30'b0, grant}, 32'd1);
            if (k == 5) chk("rr_grant_b", {30'b0, grant}, 32'd2);
            if (k < 7) chk("rr_b_wait", {31'b0, ack_b}, 32'd0);
            if (k == 7) begin
                chk("rr_ack_b", {31'b0, ack_b}, 32'd1);
                set_req(1, 0, 0, 0, 0, 0);
            end
            if (k == 11) set_req(0, 0, 0, 0, 0, 0);
        end
`endif

        // A aborts a write during ACCESS: committed, never acked.
        set_req(0, 1, 1, 10'h040, 4'hF, 32'h5555AAAA);
        @(negedge clk);
        chk("abort_csb", {31'b0, ram_csb0}, 32'd0);
        chk("abort_web", {31'b0, ram_web0}, 32'd0);
        set_req(0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("abort_no_ack", {31'b0, ack_a}, 32'd0);
        end
        txn('{0, 0, 10'h040, 4'hF, 32'h0, 32'h5555AAAA});

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_sram_port_arbiter.md
Name: wb_sram_port_arbiter

Overview:
Two-requester Wishbone arbiter that shares the single RW port (port 0) of the 1 kB sky130 OpenRAM macro (32x256, byte write mask).
- Requester A: Caravel-side traffic from the wishbone bridge.
- Requester B: user-project rambus.
- Round-robin grant per transaction; a fixed 4-cycle access sequence drives the macro's csb/web/wmask/addr/din and returns registered read data and a single-cycle ack to the granted requester.

Parameters:
- RAM_ADDR_WIDTH, 8, word address width of the SRAM macro.
- WB_ADDR_WIDTH, 10, byte address width on both Wishbone ports; must equal RAM_ADDR_WIDTH+2.

Ports:
- wb_clk_i  input  1  single clock for all logic and the SRAM.
- wb_rst_i  input  1  asynchronous, active-high reset.
- wbs_a_stb_i, wbs_a_cyc_i, wbs_a_we_i  input  1 each  port A Wishbone strobe, cycle, write enable.
- wbs_a_sel_i  input  4  port A byte selects.
- wbs_a_dat_i  input  32  port A write data.
- wbs_a_adr_i  input  WB_ADDR_WIDTH  port A byte address.
- wbs_a_ack_o  output  1  port A ack.
- wbs_a_dat_o  output  32  port A read data.
- wbs_b_*  same set as port A, for requester B.
- ram_clk0  output  1  equals wb_clk_i (combinational pass-through).
- ram_csb0  output  1  active-low chip select.
- ram_web0  output  1  active-low write enable.
- ram_wmask0  output  4  byte write mask.
- ram_addr0  output  RAM_ADDR_WIDTH  word address.
- ram_din0  output  32  write data.
- ram_dout0  input  32  read data.
- grant_o  output  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset values (async, immediate on wb_rst_i=1): state=IDLE; ram_csb0=1; ram_web0=1; ram_wmask0=0; ram_addr0=0; ram_din0=0; both ack=0; both dat_o=0; grant_o=00; last_grant=B.
- Request: port X requests when cyc&stb=1. Only IDLE samples requests.
- Arbitration at the IDLE edge (E0):
  - One requester: it wins.
  - Both requesting: the port not equal to last_grant wins, so A wins the first tie after reset.
  - The winner is written to last_grant and grant_o.
- Address and control mapping: winner's adr[WB_ADDR_WIDTH-1:2] -> ram_addr0; adr[1:0] ignored. sel -> wmask0; dat_i -> din0; web0 <= ~we.
- FSM (all outputs registered):
  - IDLE -> ACCESS at E0 if any request. ram_csb0=0 during the cycle after E0.
  - ACCESS -> RESP at E1. ram_csb0<=1, web0<=1, wmask0<=0. SRAM dout is valid during this cycle.
  - RESP -> DONE at E2.
    - If the winner's cyc&stb is still 1: ack_X<=1; dat_o_X<=ram_dout0 for a read, 0 for a write.
    - Otherwise: ack is suppressed and dat_o is unchanged.
  - DONE -> IDLE at E3. ack_X<=0; grant_o<=00.
- Latency and throughput:
  - ack is high for exactly one cycle, in the cycle after E2 (3 cycles after the request is sampled).
  - Occupancy is 4 cycles per transaction, so the next request is sampled at E4 at the earliest.
  - The non-granted port waits with ack=0; its request is never dropped and it is served next.
- Abort: if the winner drops cyc during ACCESS, the SRAM access still completes (a write is committed) but no ack is given.
- Cross-port isolation: the non-granted port's ack is always 0 and its dat_o holds its last value.
- Reset asserted mid-transaction: the access is abandoned, csb0 returns to 1 immediately, and no ack is issued after reset release.
- The SRAM RO port 1 is not touched by this block.

Optional Feature:
- Macro: WB_SRAM_ARB_LOCK_EN.
- Defined: bus lock. If the winner still holds cyc=1 when DONE->IDLE occurs, it keeps priority at the next IDLE even against a competing request. It keeps winning until it drops cyc for at least one IDLE cycle. last_grant is not toggled while the lock is held.
- Undefined: pure round-robin per transaction, as in Behaviour.

Test Plan:
- A writes adr=0x010, dat=0xDEADBEEF, sel=1111, then reads 0x010 -> ram_csb0=0 for 1 cycle with addr0=0x04, web0=0; ack_a one cycle at E0+3; read returns 0xDEADBEEF.
- Byte write: A writes 0x11223344 to 0x020, then B writes 0xAA with sel=0001 to 0x020; A reads -> 0x112233AA.
- A and B request reads in the same cycle right after reset -> A is granted first (acked at E3); B is sampled at E4 and acked at E7; grant_o reads 01 then 10.
- A issues continuous back-to-back requests while B requests once -> grants alternate A, B, A; B is acked within 8 cycles. With WB_SRAM_ARB_LOCK_EN defined and A holding cyc, B waits until A drops cyc.
- A write is started and A drops cyc during ACCESS -> no ack_a; a later read of the same address shows the new data.
- wb_rst_i is pulsed during ACCESS of a B read -> csb0=1 and ack_b=0 immediately; after release the first tie goes to A.
